// File: rtl/div20x8_signed.sv
// Signed wide-by-narrow divider: one restoring step per clock, valid/ready on both sides.
// Quotient truncates toward zero; divide-by-zero and -MIN/-1 saturate and raise a flag.
module div20x8_signed #(
    parameter int IN_WIDTH  = 20,
    parameter int DIV_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  dividend,
    input  logic signed [DIV_WIDTH-1:0] divisor,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [IN_WIDTH-1:0]  quotient,
    output logic signed [DIV_WIDTH-1:0] remainder,
    output logic                        div_by_zero,
    output logic                        overflow
);
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [IN_WIDTH-1:0] Q_MAX = {1'b0, {(IN_WIDTH-1){1'b1}}};
    localparam logic [IN_WIDTH-1:0] Q_MIN = {1'b1, {(IN_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IN_WIDTH-1:0]  r_q;
    logic [DIV_WIDTH-1:0] r_dvs;
    logic [DIV_WIDTH-1:0] r_rem;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg_dvd;
    logic                 r_neg_dvs;
    logic                 r_zero;
    logic                 w_accept;
    logic [DIV_WIDTH:0]   w_shift;
    logic [DIV_WIDTH-1:0] w_sub;
    logic                 w_qbit;
    logic                 w_ovf;

    function automatic logic [IN_WIDTH-1:0] f_abs_dvd(input logic signed [IN_WIDTH-1:0] v);
        return v[IN_WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [DIV_WIDTH-1:0] f_abs_dvs(input logic signed [DIV_WIDTH-1:0] v);
        return v[DIV_WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [IN_WIDTH-1:0] f_sat_quot(input logic [IN_WIDTH-1:0] mag,
                                                       input logic neg_dvd,
                                                       input logic neg_dvs,
                                                       input logic zero);
        if (zero)
            return neg_dvd ? Q_MIN : Q_MAX;
        // A positive result with the magnitude MSB set can only be -MIN / -1.
        if (!(neg_dvd ^ neg_dvs) && mag[IN_WIDTH-1])
            return Q_MAX;
        return (neg_dvd ^ neg_dvs) ? -mag : mag;
    endfunction

    function automatic logic [DIV_WIDTH-1:0] f_sign_rem(input logic [DIV_WIDTH-1:0] mag,
                                                        input logic neg_dvd,
                                                        input logic force_zero);
        if (force_zero)
            return '0;
        return neg_dvd ? -mag : mag;
    endfunction

    assign in_ready = rst_n && (r_state == IDLE);
    assign w_accept = in_valid && in_ready;

    // r_q shifts dividend bits out of its MSB while quotient bits enter at its LSB;
    // w_shift is the DIV_WIDTH+1-bit working remainder for this step.
    assign w_shift = {r_rem, r_q[IN_WIDTH-1]};
    assign w_qbit  = (w_shift >= {1'b0, r_dvs});
    assign w_sub   = w_shift[DIV_WIDTH-1:0] - r_dvs;
    assign w_ovf   = !r_zero && !(r_neg_dvd ^ r_neg_dvs) && r_q[IN_WIDTH-1];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (divisor == '0) ? FIX : CALC;
            CALC:    if (r_cnt == CNT_W'(1)) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) r_cnt <= CNT_W'(IN_WIDTH);
                CALC: r_cnt <= r_cnt - 1'b1;
                FIX: begin
                    out_valid   <= 1'b1;
                    quotient    <= f_sat_quot(r_q, r_neg_dvd, r_neg_dvs, r_zero);
                    remainder   <= f_sign_rem(r_rem, r_neg_dvd, r_zero || w_ovf);
                    div_by_zero <= r_zero;
                    overflow    <= w_ovf;
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_q       <= f_abs_dvd(dividend);
            r_dvs     <= f_abs_dvs(divisor);
            r_neg_dvd <= dividend[IN_WIDTH-1];
            r_neg_dvs <= divisor[DIV_WIDTH-1];
            r_zero    <= (divisor == '0);
            r_rem     <= '0;
        end else if (r_state == CALC) begin
            r_rem <= w_qbit ? w_sub : w_shift[DIV_WIDTH-1:0];
            r_q   <= {r_q[IN_WIDTH-2:0], w_qbit};
        end
    end
endmodule

// File: tb/tb_div20x8_signed.sv
// Scoreboard bench for div20x8_signed: directed sign/corner cases, backpressure,
// mid-operation reset and randomized operands against an integer-arithmetic model.
module tb_div20x8_signed;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [19:0] dividend;
    logic signed [7:0]  divisor;
    logic               out_valid;
    logic               out_ready;
    logic signed [19:0] quotient;
    logic signed [7:0]  remainder;
    logic               div_by_zero;
    logic               overflow;

    typedef struct {
        int q;
        int r;
        bit dz;
        bit ov;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    div20x8_signed dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Truncating division in SystemVerilog int arithmetic already gives the
    // round-toward-zero quotient and dividend-signed remainder.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (b == 0) begin
            e.dz = 1'b1;
            e.q  = (a >= 0) ? 524287 : -524288;
            e.r  = 0;
        end else if (a == -524288 && b == -1) begin
            e.ov = 1'b1;
            e.q  = 524287;
            e.r  = 0;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", quotient, mon_e.q);
                chk("remainder", remainder, mon_e.r);
                chk("div_by_zero", div_by_zero, mon_e.dz);
                chk("overflow", overflow, mon_e.ov);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic run_op(input logic signed [19:0] a, input logic signed [7:0] b, input int hold);
        int n;
        bit busy_rdy;
        logic signed [19:0] q0;
        logic signed [7:0]  r0;
        out_ready = (hold == 0);
        wait_ready();
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        sb.push_back(model(int'(a), int'(b)));
        @(posedge clk); #1;
        n = 0;
        busy_rdy = 1'b0;
        do begin
            if (in_ready) busy_rdy = 1'b1;
            in_valid = 1'($urandom_range(0, 1));
            dividend = 20'($urandom);
            divisor  = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 60);
        in_valid = 1'b0;
        chk("latency", n, (b == 0) ? 1 : 21);
        chk("in_ready_busy", busy_rdy, 0);
        q0 = quotient;
        r0 = remainder;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            dividend = 20'($urandom);
            divisor  = 8'($urandom);
            @(posedge clk); #1;
            chk("hold_stable", (quotient == q0 && remainder == r0 && out_valid && !in_ready), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
        chk("quotient_kept", quotient, q0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int seen;
        logic signed [19:0] ra;
        logic signed [7:0]  rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_flags", {div_by_zero, overflow}, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_release", in_ready, 1);

        run_op(20'sd100, 8'sd7, 0);
        run_op(-20'sd100, 8'sd7, 0);
        run_op(20'sd100, -8'sd7, 0);
        run_op(-20'sd100, -8'sd7, 0);
        run_op(20'sd524287, -8'sd128, 0);
        run_op(-20'sd524288, 8'sd127 + 8'sd1, 0);
        run_op(-20'sd524288, -8'sd1, 0);
        run_op(20'sd5, 8'sd0, 0);
        run_op(-20'sd5, 8'sd0, 0);
        run_op(20'sd0, 8'sd0, 0);
        run_op(20'sd1234, -8'sd9, 10);
        run_op(20'sd77, 8'sd5, 0);

        // Abort an operation at edge 8 after its accept edge.
        out_ready = 1'b1;
        wait_ready();
        dividend = 20'sd1000;
        divisor  = 8'sd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_flags", {div_by_zero, overflow}, 0);
        chk("abort_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("abort_no_valid", seen, 0);
        run_op(20'sd1000, 8'sd3, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0:       ra = -20'sd524288;
                1:       ra = 20'sd524287;
                default: ra = 20'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 8'sd0;
                1:       rb = -8'sd1;
                2:       rb = -8'sd128;
                default: rb = 8'($urandom);
            endcase
            run_op(ra, rb, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
